// File: rtl/m_dram_axi_master.sv
// ----------------------------------------------------------------------------
// m_dram_axi_master
//
// Single-outstanding AXI4 master that sits between the core memory port and
// the MIG AXI slave, entirely in the MIG user clock domain. Each accepted
// request becomes exactly one single-beat AXI4 transaction (write: AW+W then B,
// read: AR then R). Completion is reported on a one-cycle rsp_valid strobe.
// No request is accepted before DRAM calibration has completed.
//
// Optional feature: define DRAM_RESP_CHECK_EN to enable the sticky err flag
// (non-OKAY bresp/rresp or a read beat without rlast). Without the macro err
// is tied low and the response/last fields are ignored.
//
// Ports
//   ui_clk, ui_rst          clock, synchronous active-high reset
//   init_calib_complete     MIG calibration done; gates req_ready only
//   req_*                   request channel (valid/ready, we, addr, wdata, wstrb)
//   rsp_valid, rsp_rdata    one-cycle completion strobe and read data
//   err                     sticky response error (DRAM_RESP_CHECK_EN only)
//   s_axi_aw*/w*/b*         AXI4 write address / data / response channels
//   s_axi_ar*/r*            AXI4 read address / data channels
// ----------------------------------------------------------------------------
module m_dram_axi_master #(
    parameter int         APP_ADDR_WIDTH = 28,
    parameter int         APP_DATA_WIDTH = 128,
    parameter int         APP_MASK_WIDTH = 16,
    parameter logic [3:0] AXI_ID         = 4'd0
) (
    input  logic                      ui_clk,
    input  logic                      ui_rst,
    input  logic                      init_calib_complete,

    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic [APP_ADDR_WIDTH-1:0] req_addr,
    input  logic [APP_DATA_WIDTH-1:0] req_wdata,
    input  logic [APP_MASK_WIDTH-1:0] req_wstrb,

    output logic                      rsp_valid,
    output logic [APP_DATA_WIDTH-1:0] rsp_rdata,
    output logic                      err,

    output logic [3:0]                s_axi_awid,
    output logic [APP_ADDR_WIDTH-1:0] s_axi_awaddr,
    output logic [7:0]                s_axi_awlen,
    output logic [2:0]                s_axi_awsize,
    output logic [1:0]                s_axi_awburst,
    output logic                      s_axi_awlock,
    output logic [3:0]                s_axi_awcache,
    output logic [2:0]                s_axi_awprot,
    output logic [3:0]                s_axi_awqos,
    output logic                      s_axi_awvalid,
    input  logic                      s_axi_awready,

    output logic [APP_DATA_WIDTH-1:0] s_axi_wdata,
    output logic [APP_MASK_WIDTH-1:0] s_axi_wstrb,
    output logic                      s_axi_wlast,
    output logic                      s_axi_wvalid,
    input  logic                      s_axi_wready,

    input  logic [3:0]                s_axi_bid,
    input  logic [1:0]                s_axi_bresp,
    input  logic                      s_axi_bvalid,
    output logic                      s_axi_bready,

    output logic [3:0]                s_axi_arid,
    output logic [APP_ADDR_WIDTH-1:0] s_axi_araddr,
    output logic [7:0]                s_axi_arlen,
    output logic [2:0]                s_axi_arsize,
    output logic [1:0]                s_axi_arburst,
    output logic                      s_axi_arlock,
    output logic [3:0]                s_axi_arcache,
    output logic [2:0]                s_axi_arprot,
    output logic [3:0]                s_axi_arqos,
    output logic                      s_axi_arvalid,
    input  logic                      s_axi_arready,

    input  logic [3:0]                s_axi_rid,
    input  logic [APP_DATA_WIDTH-1:0] s_axi_rdata,
    input  logic [1:0]                s_axi_rresp,
    input  logic                      s_axi_rlast,
    input  logic                      s_axi_rvalid,
    output logic                      s_axi_rready
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_WR_B,
        ST_RD_AR,
        ST_RD_R
    } state_t;

    state_t                    state_reg;
    logic [APP_ADDR_WIDTH-1:0] addr_reg;
    logic [APP_DATA_WIDTH-1:0] wdata_reg;
    logic [APP_MASK_WIDTH-1:0] wstrb_reg;
    logic [APP_DATA_WIDTH-1:0] rsp_rdata_reg;
    logic                      awvalid_reg;
    logic                      wvalid_reg;
    logic                      bready_reg;
    logic                      arvalid_reg;
    logic                      rready_reg;
    logic                      rsp_valid_reg;

    // A channel counts as done once its valid has already been retired, or
    // when its handshake lands this cycle. awvalid/wvalid are raised together
    // on accept, so a low valid inside ST_WR means that beat already went out.
    logic aw_done;
    logic w_done;
    assign aw_done = !awvalid_reg || s_axi_awready;
    assign w_done  = !wvalid_reg  || s_axi_wready;

    // The only combinational output. Held low while the completion strobe is
    // out so the core never sees accept and response in the same cycle.
    assign req_ready = (state_reg == ST_IDLE) && !rsp_valid_reg &&
                       init_calib_complete && !ui_rst;

    // Fixed single-beat, 16-byte, INCR, modifiable/bufferable attributes.
    assign s_axi_awid    = AXI_ID;
    assign s_axi_awaddr  = addr_reg;
    assign s_axi_awlen   = 8'd0;
    assign s_axi_awsize  = 3'b100;
    assign s_axi_awburst = 2'b01;
    assign s_axi_awlock  = 1'b0;
    assign s_axi_awcache = 4'b0011;
    assign s_axi_awprot  = 3'b000;
    assign s_axi_awqos   = 4'd0;
    assign s_axi_awvalid = awvalid_reg;

    assign s_axi_wdata   = wdata_reg;
    assign s_axi_wstrb   = wstrb_reg;
    assign s_axi_wlast   = 1'b1;
    assign s_axi_wvalid  = wvalid_reg;

    assign s_axi_bready  = bready_reg;

    assign s_axi_arid    = AXI_ID;
    assign s_axi_araddr  = addr_reg;
    assign s_axi_arlen   = 8'd0;
    assign s_axi_arsize  = 3'b100;
    assign s_axi_arburst = 2'b01;
    assign s_axi_arlock  = 1'b0;
    assign s_axi_arcache = 4'b0011;
    assign s_axi_arprot  = 3'b000;
    assign s_axi_arqos   = 4'd0;
    assign s_axi_arvalid = arvalid_reg;

    assign s_axi_rready  = rready_reg;

    assign rsp_valid     = rsp_valid_reg;
    assign rsp_rdata     = rsp_rdata_reg;

    always_ff @(posedge ui_clk) begin
        if (ui_rst) begin
            state_reg     <= ST_IDLE;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            wstrb_reg     <= '0;
            rsp_rdata_reg <= '0;
            awvalid_reg   <= 1'b0;
            wvalid_reg    <= 1'b0;
            bready_reg    <= 1'b0;
            arvalid_reg   <= 1'b0;
            rready_reg    <= 1'b0;
            rsp_valid_reg <= 1'b0;
        end else begin
            rsp_valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        // Beats are 16 bytes; the low nibble is never sent.
                        addr_reg <= {req_addr[APP_ADDR_WIDTH-1:4], 4'b0000};
                        if (req_we) begin
                            wdata_reg   <= req_wdata;
                            wstrb_reg   <= req_wstrb;
                            awvalid_reg <= 1'b1;
                            wvalid_reg  <= 1'b1;
                            state_reg   <= ST_WR;
                        end else begin
                            arvalid_reg <= 1'b1;
                            state_reg   <= ST_RD_AR;
                        end
                    end
                end
                ST_WR: begin
                    if (s_axi_awready) begin
                        awvalid_reg <= 1'b0;
                    end
                    if (s_axi_wready) begin
                        wvalid_reg <= 1'b0;
                    end
                    if (aw_done && w_done) begin
                        bready_reg <= 1'b1;
                        state_reg  <= ST_WR_B;
                    end
                end
                ST_WR_B: begin
                    if (s_axi_bvalid) begin
                        bready_reg    <= 1'b0;
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= ST_IDLE;
                    end
                end
                ST_RD_AR: begin
                    if (s_axi_arready) begin
                        arvalid_reg <= 1'b0;
                        rready_reg  <= 1'b1;
                        state_reg   <= ST_RD_R;
                    end
                end
                ST_RD_R: begin
                    if (s_axi_rvalid) begin
                        rready_reg    <= 1'b0;
                        rsp_rdata_reg <= s_axi_rdata;
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef DRAM_RESP_CHECK_EN
    // bready/rready are held high for the whole of their states, so a valid
    // seen in that state is the handshake.
    logic err_reg;
    always_ff @(posedge ui_clk) begin
        if (ui_rst) begin
            err_reg <= 1'b0;
        end else if ((state_reg == ST_WR_B && s_axi_bvalid && s_axi_bresp != 2'b00) ||
                     (state_reg == ST_RD_R && s_axi_rvalid &&
                      (s_axi_rresp != 2'b00 || !s_axi_rlast))) begin
            err_reg <= 1'b1;
        end
    end
    assign err = err_reg;

    logic unused_ok;
    assign unused_ok = ^{req_addr[3:0], s_axi_bid, s_axi_rid};
`else
    assign err = 1'b0;

    logic unused_ok;
    assign unused_ok = ^{req_addr[3:0], s_axi_bid, s_axi_rid,
                         s_axi_bresp, s_axi_rresp, s_axi_rlast};
`endif

endmodule
